mult_share_arb: RTL and testbench
=================================

# mult_share_arb

Round-robin arbiter and two-stage pipeline that shares one signed fixed-point multiplier among NUM_REQ requesters in the LSTM datapath, such as the gate units and the cell-state update. Each requester offers an operand pair with a valid/ready handshake. The block grants one request per cycle, multiplies the operands, and returns the fixed-point product tagged with the requester ID. The product is the DATA_WID-bit slice of the full product starting at bit AUG_FCT_B, so results wrap and are truncated. The output accepts back-pressure.

## Interface
- DATA_WID, default `CNN_XLEN`: operand and result width, signed two's complement.
- AUG_FCT_B, default `AUG_FCT_B`: number of fractional bits; the result is product[AUG_FCT_B +: DATA_WID].
- NUM_REQ, default 4: number of requesters, must be ≥2.
- ID_WID, default $clog2(NUM_REQ): width of the requester tag.

Ports:
- clock  in  1  the single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  NUM_REQ  bit i set means requester i offers an operand pair.
- req_a  in  NUM_REQ*DATA_WID  operand A of requester i, in slice [i*DATA_WID +: DATA_WID].
- req_b  in  NUM_REQ*DATA_WID  operand B of requester i, same slicing.
- req_ready  out  NUM_REQ  one-hot or zero; bit i set means requester i's operands are accepted this cycle.
- res_valid  out  1  result available.
- res_data  out  DATA_WID  signed truncated product.
- res_id  out  ID_WID  index of the requester that issued the result.
- res_ready  in  1  consumer accepts the result this cycle.
- busy  out  1  high when either pipeline stage holds valid data.

## Operation
- Stage S1 register holds a1, b1, id1 and v1. Stage S2 register holds p2, id2 and v2.
- res_valid=v2, res_data=p2, res_id=id2, busy=v1|v2.
- Advance conditions:
  - adv2 = !v2 | res_ready
  - adv1 = !v1 | adv2
- Arbitration is combinational. Starting at pointer rr_ptr, search upward with wrap for the first i with req_valid[i]=1.
  - If one is found and adv1=1, set req_ready[i]=1. All other bits are 0.
  - req_ready never asserts when adv1=0.
- Accept, i.e. req_valid[i] & req_ready[i]:
  - S1 loads a1=req_a[i], b1=req_b[i], id1=i, v1=1.
  - rr_ptr becomes (i+1) mod NUM_REQ.
- No accept while adv1=1: v1 becomes 0 and rr_ptr is unchanged.
- S1 to S2 when adv2=1:
  - p2 is the bit slice of the full 2*DATA_WID signed product a1*b1 starting at bit AUG_FCT_B.
  - id2=id1, v2=v1.
- Arithmetic: the full product is 2*DATA_WID bits signed. There is no rounding and no saturation, and overflow wraps by truncation.
- Stall: when v2=1 and res_ready=0, p2, id2 and v2 hold, and S1 holds if v1=1. res_data and res_id must stay stable while res_valid=1 and res_ready=0.
- Requesters must hold their valid and operands until ready. A requester that drops req_valid before being granted is simply skipped, with no error.
- Fairness: with all NUM_REQ requesters continuously valid and no stall, grants cycle 0,1,…,NUM_REQ-1,0,… Each requester waits at most NUM_REQ-1 grants between its own.
- Reset:
  - v1=0, v2=0, rr_ptr=0.
  - All outputs read 0: req_ready, res_valid, res_data, res_id, busy.
  - a1, b1 and p2 are cleared to 0.
  - Reset mid-operation discards in-flight results with no partial output.
  - req_ready is forced to 0 during the reset cycle.

## Timing
- Latency: operands accepted at edge N appear on res_valid/res_data after edge N+1, so result-to-accept latency is 2 cycles with no stall.
- Throughput is 1 result per cycle when res_ready stays high.
- req_ready depends combinationally on req_valid, rr_ptr, v1, v2 and res_ready. There is no combinational path from req_a/req_b to any output.
- Simultaneous events: with S2 full, S1 full and res_ready=1 in the same cycle, S2 drains, S1 moves to S2, and a new request is accepted into S1 in that one cycle.
- Capacity: at most 2 results are in flight. After res_ready deasserts, at most one further accept can occur before req_ready drops, namely the one filling an empty S1.

## Test plan
Bench configuration for all scenarios: DATA_WID=16, AUG_FCT_B=8 (Q8.8), NUM_REQ=4.

1. Single request, no stall:
   - Requester 2 offers a=0x0180 (1.5), b=0x0200 (2.0) at cycle 0.
   - Required: req_ready=4'b0100 at cycle 0, then res_valid=1, res_data=0x0300, res_id=2 at cycle 2, then busy=0 at cycle 3.
2. Sign and overflow:
   - 0xFF00 × 0x0080 must give 0xFF80 (−1.0 × 0.5 = −0.5).
   - 0x7FFF × 0x7FFF must give 0xFF00 (wrapped slice of 0x3FFF0001).
   - 0x8000 × 0x8000 must give 0x0000.
3. Round-robin:
   - All four requesters valid continuously for 8 cycles with res_ready=1.
   - Required: res_id sequence 0,1,2,3,0,1,2,3, each with the correct product, and no gaps after the first result.
4. Back-pressure:
   - Hold res_ready=0 for 5 cycles after the first result while requesters 0 and 1 stay valid.
   - Required: res_data and res_id are stable; exactly one extra accept occurs, then req_ready=0.
   - After release, results drain in order with no loss or duplication.
5. Reset mid-operation:
   - Assert reset for 1 cycle with v1=1 and v2=1.
   - Required: the next cycle shows res_valid=0, busy=0, req_ready=0.
   - Arbitration restarts at requester 0: with requesters 1 and 3 valid, requester 1 is granted first.
6. Pointer skip:
   - Only requester 3 is valid, then only requester 1.
   - Required: grants go 3 then 1, rr_ptr=2 afterwards, and the next simultaneous 0/2 request grants requester 2 first.

Source files
------------

// File: rtl/mult_share_arb.sv
// Round-robin share of one signed fixed-point multiplier among NUM_REQ requesters, result tagged with requester id.
// Latency 2 cycles accept-to-result; res_ready low stalls S2, then S1, then drops req_ready (2 results max in flight).

`ifndef CNN_XLEN
`define CNN_XLEN 16
`endif
`ifndef AUG_FCT_B
`define AUG_FCT_B 8
`endif

module mult_share_arb #(
  parameter int DATA_WID  = `CNN_XLEN,
  parameter int AUG_FCT_B = `AUG_FCT_B,
  parameter int NUM_REQ   = 4,
  parameter int ID_WID    = $clog2(NUM_REQ)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*DATA_WID-1:0]  req_a,
  input  logic [NUM_REQ*DATA_WID-1:0]  req_b,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic                         res_valid,
  output logic [DATA_WID-1:0]          res_data,
  output logic [ID_WID-1:0]            res_id,
  input  logic                         res_ready,
  output logic                         busy
);

  localparam logic [ID_WID:0]   NREQ_W   = (ID_WID+1)'(NUM_REQ);
  localparam logic [ID_WID-1:0] LAST_IDX = ID_WID'(NUM_REQ - 1);

  logic signed [DATA_WID-1:0]   a1, b1;
  logic [ID_WID-1:0]            id1;
  logic                         v1;
  logic [DATA_WID-1:0]          p2;
  logic [ID_WID-1:0]            id2;
  logic                         v2;
  logic [ID_WID-1:0]            rr_ptr;

  logic                         adv1, adv2;
  logic                         gnt_found;
  logic [ID_WID-1:0]            gnt_idx;
  logic [ID_WID:0]              cand_sum;
  logic [ID_WID-1:0]            cand;
  logic                         accept;
  logic signed [2*DATA_WID-1:0] prod_full;
  logic                         unused_prod;

  assign adv2 = !v2 || res_ready;
  assign adv1 = !v1 || adv2;

  // First valid requester at or above rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand_sum  = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_sum = {1'b0, rr_ptr} + (ID_WID+1)'(k);
      if (cand_sum >= NREQ_W)
        cand_sum = cand_sum - NREQ_W;
      cand = cand_sum[ID_WID-1:0];
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (!reset && adv1 && gnt_found)
      req_ready[gnt_idx] = 1'b1;
  end

  assign accept = |(req_valid & req_ready);

  assign prod_full   = a1 * b1;
  assign unused_prod = ^prod_full;

  always_ff @(posedge clock) begin
    if (reset) begin
      a1     <= '0;
      b1     <= '0;
      id1    <= '0;
      v1     <= 1'b0;
      p2     <= '0;
      id2    <= '0;
      v2     <= 1'b0;
      rr_ptr <= '0;
    end else begin
      if (adv1) begin
        v1 <= accept;
        if (accept) begin
          a1     <= req_a[gnt_idx*DATA_WID +: DATA_WID];
          b1     <= req_b[gnt_idx*DATA_WID +: DATA_WID];
          id1    <= gnt_idx;
          rr_ptr <= (gnt_idx == LAST_IDX) ? '0 : gnt_idx + 1'b1;
        end
      end
      if (adv2) begin
        p2  <= prod_full[AUG_FCT_B +: DATA_WID];
        id2 <= id1;
        v2  <= v1;
      end
    end
  end

  assign res_valid = v2;
  assign res_data  = p2;
  assign res_id    = id2;
  assign busy      = v1 || v2;

  a_ready_onehot: assert property (@(posedge clock) disable iff (reset) $onehot0(req_ready));
  a_ready_stall:  assert property (@(posedge clock) disable iff (reset) (!adv1 |-> req_ready == '0));

endmodule

// File: tb/tb_mult_share_arb.sv
// Randomized bench for mult_share_arb with a queue-based scoreboard model of the two-slot pipeline.
module tb_mult_share_arb;

  localparam int DW = 16;
  localparam int FB = 8;
  localparam int NR = 4;
  localparam int IW = 2;

  logic              clock = 1'b0;
  logic              reset;
  logic [NR-1:0]     req_valid;
  logic [NR*DW-1:0]  req_a, req_b;
  logic [NR-1:0]     req_ready;
  logic              res_valid;
  logic [DW-1:0]     res_data;
  logic [IW-1:0]     res_id;
  logic              res_ready;
  logic              busy;

  logic [NR-1:0]     rv;
  logic [DW-1:0]     ra [NR];
  logic [DW-1:0]     rb [NR];

  always #5 clock = ~clock;

  always_comb begin
    req_valid = rv;
    req_a     = '0;
    req_b     = '0;
    for (int i = 0; i < NR; i++) begin
      req_a[i*DW +: DW] = ra[i];
      req_b[i*DW +: DW] = rb[i];
    end
  end

  mult_share_arb #(.DATA_WID(DW), .AUG_FCT_B(FB), .NUM_REQ(NR), .ID_WID(IW)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .res_valid(res_valid), .res_data(res_data), .res_id(res_id), .res_ready(res_ready),
    .busy(busy)
  );

  // Model: in-flight results in accept order, each tagged with the stage it occupies.
  typedef struct {
    logic [IW-1:0] id;
    logic [DW-1:0] p;
    int            stage;
  } ent_t;

  ent_t          q[$];
  int            ptr;
  int            n_chk = 0;
  int            n_err = 0;
  int            mode;        // 0: drop on grant, 1: stay valid with new operands, 2: random traffic
  logic          m_s1, m_s2, m_adv1, m_adv2, g_ok;
  int            g_idx;
  logic [NR-1:0] exp_rdy;
  int            extra;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] fxmul(input logic [DW-1:0] a, input logic [DW-1:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    p = p >>> FB;
    return p[DW-1:0];
  endfunction

  function automatic logic [DW-1:0] rand_op();
    case ($urandom % 8)
      0:       return 16'h8000;
      1:       return 16'h7FFF;
      2:       return 16'hFFFF;
      default: return DW'($urandom);
    endcase
  endfunction

  task automatic settle();
    @(negedge clock);
    m_s2 = (q.size() > 0) && (q[0].stage == 2);
    m_s1 = 1'b0;
    foreach (q[i]) if (q[i].stage == 1) m_s1 = 1'b1;
    m_adv2 = !m_s2 || res_ready;
    m_adv1 = !m_s1 || m_adv2;
    g_ok   = 1'b0;
    g_idx  = 0;
    if (!reset && m_adv1)
      for (int k = 0; k < NR; k++)
        if (!g_ok && rv[(ptr + k) % NR]) begin
          g_ok  = 1'b1;
          g_idx = (ptr + k) % NR;
        end
    exp_rdy = g_ok ? NR'(1 << g_idx) : '0;
    check_val("req_ready", 32'(req_ready), 32'(exp_rdy));
    check_val("res_valid", 32'(res_valid), 32'(m_s2));
    if (m_s2) begin
      check_val("res_data", 32'(res_data), 32'(q[0].p));
      check_val("res_id", 32'(res_id), 32'(q[0].id));
    end
    check_val("busy", 32'(busy), 32'(q.size() != 0));
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    if (reset) begin
      q.delete();
      ptr = 0;
    end else begin
      if (m_s2 && res_ready) void'(q.pop_front());
      if (m_adv2) foreach (q[i]) if (q[i].stage == 1) q[i].stage = 2;
      if (g_ok) begin
        q.push_back('{id: IW'(g_idx), p: fxmul(ra[g_idx], rb[g_idx]), stage: 1});
        ptr = (g_idx + 1) % NR;
      end
    end
    if (g_ok) begin
      if (mode == 1) begin
        ra[g_idx] = rand_op();
        rb[g_idx] = rand_op();
      end else
        rv[g_idx] = 1'b0;
    end
    if (mode == 2) begin
      for (int i = 0; i < NR; i++) begin
        if (!rv[i] && ($urandom % 2 == 0)) begin
          rv[i] = 1'b1;
          ra[i] = rand_op();
          rb[i] = rand_op();
        end else if (rv[i] && ($urandom % 16 == 0))
          rv[i] = 1'b0;
      end
      res_ready = ($urandom % 4) != 0;
      reset     = ($urandom % 300) == 0;
    end
  endtask

  task automatic cycle();
    settle();
    step();
  endtask

  task automatic run_one(input int r, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [DW-1:0] expd, input string tag);
    mode  = 0;
    rv[r] = 1'b1;
    ra[r] = a;
    rb[r] = b;
    cycle();
    cycle();
    settle();
    check_val(tag, 32'(res_data), 32'(expd));
    step();
  endtask

  initial begin
    reset     = 1'b1;
    res_ready = 1'b1;
    rv        = '0;
    mode      = 0;
    ptr       = 0;
    extra     = 0;
    for (int i = 0; i < NR; i++) begin
      ra[i] = '0;
      rb[i] = '0;
    end
    repeat (2) @(posedge clock);
    #1;

    // Reset state
    cycle();
    settle();
    check_val("rst_res_data", 32'(res_data), 32'h0);
    check_val("rst_res_id", 32'(res_id), 32'h0);
    step();
    reset = 1'b0;

    // Single request, 1.5 * 2.0
    rv[2] = 1'b1;
    ra[2] = 16'h0180;
    rb[2] = 16'h0200;
    settle();
    check_val("s1_ready", 32'(req_ready), 32'h4);
    step();
    cycle();
    settle();
    check_val("s1_valid", 32'(res_valid), 32'h1);
    check_val("s1_data", 32'(res_data), 32'h0300);
    check_val("s1_id", 32'(res_id), 32'h2);
    step();
    settle();
    check_val("s1_busy", 32'(busy), 32'h0);
    step();

    // Sign and overflow
    run_one(0, 16'hFF00, 16'h0080, 16'hFF80, "neg_half");
    run_one(0, 16'h7FFF, 16'h7FFF, 16'hFF00, "max_sq");
    run_one(0, 16'h8000, 16'h8000, 16'h0000, "min_sq");

    // Round-robin from a fresh pointer
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    mode  = 1;
    rv    = '1;
    for (int i = 0; i < NR; i++) begin
      ra[i] = rand_op();
      rb[i] = rand_op();
    end
    cycle();
    cycle();
    for (int k = 0; k < 8; k++) begin
      settle();
      check_val("rr_valid", 32'(res_valid), 32'h1);
      check_val("rr_id", 32'(res_id), 32'(k % NR));
      step();
    end
    rv = '0;
    repeat (3) cycle();

    // Back-pressure with an empty S1 when the stall begins
    mode  = 0;
    rv[0] = 1'b1;
    ra[0] = 16'h0100;
    rb[0] = 16'h0300;
    cycle();
    cycle();
    res_ready = 1'b0;
    mode      = 1;
    rv        = 4'b0011;
    for (int i = 0; i < 2; i++) begin
      ra[i] = rand_op();
      rb[i] = rand_op();
    end
    for (int h = 0; h < 5; h++) begin
      settle();
      if ((req_ready & rv) != '0) extra++;
      check_val("bp_valid", 32'(res_valid), 32'h1);
      check_val("bp_data", 32'(res_data), 32'h0300);
      check_val("bp_id", 32'(res_id), 32'h0);
      if (h == 4) check_val("bp_rdy_low", 32'(req_ready), 32'h0);
      step();
    end
    check_val("bp_extra", 32'(extra), 32'h1);
    res_ready = 1'b1;
    repeat (4) cycle();
    rv = '0;
    repeat (3) cycle();

    // Reset mid-operation
    rv = '1;
    repeat (3) cycle();
    reset = 1'b1;
    mode  = 0;
    rv    = 4'b1010;
    settle();
    check_val("rst_mid_rdy", 32'(req_ready), 32'h0);
    step();
    reset = 1'b0;
    settle();
    check_val("post_rst_valid", 32'(res_valid), 32'h0);
    check_val("post_rst_busy", 32'(busy), 32'h0);
    check_val("post_rst_grant", 32'(req_ready), 32'h2);
    step();
    repeat (5) cycle();

    // Pointer skip
    rv = 4'b1000;
    settle();
    check_val("skip_g3", 32'(req_ready), 32'h8);
    step();
    rv = 4'b0010;
    settle();
    check_val("skip_g1", 32'(req_ready), 32'h2);
    step();
    rv = 4'b0101;
    settle();
    check_val("skip_g2", 32'(req_ready), 32'h4);
    step();
    repeat (4) cycle();

    // Random traffic with back-pressure, dropped requests and occasional reset
    mode = 2;
    repeat (3000) cycle();
    mode      = 0;
    reset     = 1'b0;
    res_ready = 1'b1;
    rv        = '0;
    repeat (4) cycle();
    check_val("drain_empty", 32'(q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
